// File: rtl/rv_pkg.sv
// Shared widths and constants for the register file and its read ports.
package rv_pkg;
    localparam int XLEN    = 32;
    localparam int REG_NUM = 32;
    localparam int ROB_IDW = 5;
    localparam int REG_IDW = $clog2(REG_NUM);
    localparam int NUM_RD  = 2;

    localparam logic [ROB_IDW-1:0] NO_DEP = '0;

    typedef logic [XLEN-1:0]    word_t;
    typedef logic [ROB_IDW-1:0] rob_id_t;
    typedef logic [REG_IDW-1:0] reg_id_t;

    typedef struct packed {
        logic    vld;
        rob_id_t rob_id;
        reg_id_t rd;
        word_t   value;
    } commit_t;
endpackage

// File: rtl/rf_read_port.sv
// One combinational lookup port: tag/value from state, with a same-cycle commit bypass.
module rf_read_port
    import rv_pkg::*;
(
    input  logic [REG_NUM-1:0][ROB_IDW-1:0] deps,
    input  logic [REG_NUM-1:0][XLEN-1:0]    values,
    input  commit_t                         commit,
    input  reg_id_t                         ask,
    output rob_id_t                         dep,
    output word_t                           value
);
    logic hit;

    // Only a commit that retires the current producer may short-circuit the lookup.
    assign hit = commit.vld && (commit.rd == ask) && (deps[ask] == commit.rob_id);

    always_comb begin
        dep   = deps[ask];
        value = values[ask];
        if (hit) begin
            dep   = NO_DEP;
            value = commit.value;
        end
    end
endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags; ROB launch/commit/query responder.
module register_file
    import rv_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               _clear,
    input  logic               _rf_launch_ready,
    input  logic [ROB_IDW-1:0] _rf_launch_rob_id,
    input  logic [REG_IDW-1:0] _rf_launch_register_id,
    input  logic               _rf_commit_ready,
    input  logic [ROB_IDW-1:0] _rf_commit_rob_id,
    input  logic [REG_IDW-1:0] _rf_commit_register_id,
    input  logic [XLEN-1:0]    _rf_commit_value,
    input  logic [REG_IDW-1:0] _ask_rd_1,
    input  logic [REG_IDW-1:0] _ask_rd_2,
    output logic [ROB_IDW-1:0] _dep_rd_1,
    output logic [ROB_IDW-1:0] _dep_rd_2,
    output logic [XLEN-1:0]    _dep_value_1,
    output logic [XLEN-1:0]    _dep_value_2
);
    logic [REG_NUM-1:0][ROB_IDW-1:0] deps;
    logic [REG_NUM-1:0][XLEN-1:0]    values;
    commit_t                         commit;
    logic                            launch_vld;

    logic [NUM_RD-1:0][REG_IDW-1:0]  ask;
    logic [NUM_RD-1:0][ROB_IDW-1:0]  dep_o;
    logic [NUM_RD-1:0][XLEN-1:0]     val_o;

    assign commit.vld    = rdy_in && _rf_commit_ready && (_rf_commit_register_id != '0);
    assign commit.rob_id = _rf_commit_rob_id;
    assign commit.rd     = _rf_commit_register_id;
    assign commit.value  = _rf_commit_value;

    assign launch_vld = rdy_in && _rf_launch_ready && (_rf_launch_register_id != '0) && !_clear;

    // Entry 0 is never written, so x0 reads zero without special-casing the ports.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            deps   <= '0;
            values <= '0;
        end else if (rdy_in) begin
            if (commit.vld) begin
                values[commit.rd] <= commit.value;
                if (deps[commit.rd] == commit.rob_id)
                    deps[commit.rd] <= NO_DEP;
            end
            // Later assignments win: flush over stale-clear, launch tag over commit clear.
            if (_clear)
                deps <= '0;
            else if (launch_vld)
                deps[_rf_launch_register_id] <= _rf_launch_rob_id;
        end
    end

    assign ask[0] = _ask_rd_1;
    assign ask[1] = _ask_rd_2;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        rf_read_port u_port (
            .deps   (deps),
            .values (values),
            .commit (commit),
            .ask    (ask[p]),
            .dep    (dep_o[p]),
            .value  (val_o[p])
        );
    end

    assign _dep_rd_1    = dep_o[0];
    assign _dep_rd_2    = dep_o[1];
    assign _dep_value_1 = val_o[0];
    assign _dep_value_2 = val_o[1];
endmodule

// File: tb/tb_register_file.sv
// Directed checks of reset, rename tags, commit bypass, flush and x0/rdy handling.
module tb_register_file;
    logic        clk_in = 0;
    logic        rst_in, rdy_in, _clear;
    logic        _rf_launch_ready, _rf_commit_ready;
    logic [4:0]  _rf_launch_rob_id, _rf_launch_register_id;
    logic [4:0]  _rf_commit_rob_id, _rf_commit_register_id;
    logic [31:0] _rf_commit_value;
    logic [4:0]  _ask_rd_1, _ask_rd_2, _dep_rd_1, _dep_rd_2;
    logic [31:0] _dep_value_1, _dep_value_2;

    int passed = 0;
    int total  = 0;

    always #5 clk_in = ~clk_in;

    register_file dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(_clear),
        ._rf_launch_ready(_rf_launch_ready), ._rf_launch_rob_id(_rf_launch_rob_id),
        ._rf_launch_register_id(_rf_launch_register_id),
        ._rf_commit_ready(_rf_commit_ready), ._rf_commit_rob_id(_rf_commit_rob_id),
        ._rf_commit_register_id(_rf_commit_register_id), ._rf_commit_value(_rf_commit_value),
        ._ask_rd_1(_ask_rd_1), ._ask_rd_2(_ask_rd_2),
        ._dep_rd_1(_dep_rd_1), ._dep_rd_2(_dep_rd_2),
        ._dep_value_1(_dep_value_1), ._dep_value_2(_dep_value_2)
    );

    task automatic idle();
        _clear = 0; _rf_launch_ready = 0; _rf_commit_ready = 0;
        _rf_launch_rob_id = 0; _rf_launch_register_id = 0;
        _rf_commit_rob_id = 0; _rf_commit_register_id = 0; _rf_commit_value = 0;
    endtask

    // Inputs change on the falling edge; state updates on the next rising edge.
    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
        idle();
        #1;
    endtask

    task automatic launch(input logic [4:0] rd, input logic [4:0] id);
        _rf_launch_ready = 1; _rf_launch_register_id = rd; _rf_launch_rob_id = id;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [4:0] id, input logic [31:0] v);
        _rf_commit_ready = 1; _rf_commit_register_id = rd; _rf_commit_rob_id = id; _rf_commit_value = v;
    endtask

    task automatic test_reset();
        rst_in = 1; rdy_in = 1; idle(); _ask_rd_1 = 5; _ask_rd_2 = 31;
        @(negedge clk_in); @(negedge clk_in);
        rst_in = 0; #1;
        total++; if (_dep_rd_1 !== 5'd0) $display("FAIL reset_dep_x5 got %0d want 0", _dep_rd_1); else passed++;
        total++; if (_dep_value_1 !== 32'd0) $display("FAIL reset_val_x5 got %h want 0", _dep_value_1); else passed++;
        total++; if (_dep_rd_2 !== 5'd0) $display("FAIL reset_dep_x31 got %0d want 0", _dep_rd_2); else passed++;
        total++; if (_dep_value_2 !== 32'd0) $display("FAIL reset_val_x31 got %h want 0", _dep_value_2); else passed++;
    endtask

    task automatic test_launch_commit();
        launch(3, 7); _ask_rd_1 = 3; _ask_rd_2 = 3; step();
        total++; if (_dep_rd_1 !== 5'd7) $display("FAIL launch_dep_x3 got %0d want 7", _dep_rd_1); else passed++;
        commit(3, 7, 32'hDEADBEEF); #1;
        total++; if (_dep_rd_2 !== 5'd0) $display("FAIL bypass_dep_x3 got %0d want 0", _dep_rd_2); else passed++;
        total++; if (_dep_value_2 !== 32'hDEADBEEF) $display("FAIL bypass_val_x3 got %h want deadbeef", _dep_value_2); else passed++;
        step();
        total++; if (_dep_rd_1 !== 5'd0) $display("FAIL state_dep_x3 got %0d want 0", _dep_rd_1); else passed++;
        total++; if (_dep_value_1 !== 32'hDEADBEEF) $display("FAIL state_val_x3 got %h want deadbeef", _dep_value_1); else passed++;
    endtask

    task automatic test_stale_commit();
        _ask_rd_1 = 4; _ask_rd_2 = 4;
        launch(4, 2); step();
        launch(4, 9); step();
        commit(4, 2, 32'h11); #1;
        total++; if (_dep_rd_1 !== 5'd9) $display("FAIL stale_nobypass_dep got %0d want 9", _dep_rd_1); else passed++;
        total++; if (_dep_value_1 !== 32'h0) $display("FAIL stale_nobypass_val got %h want 0", _dep_value_1); else passed++;
        step();
        total++; if (_dep_rd_1 !== 5'd9) $display("FAIL stale_dep_kept got %0d want 9", _dep_rd_1); else passed++;
        total++; if (_dep_value_2 !== 32'h11) $display("FAIL stale_val got %h want 11", _dep_value_2); else passed++;
        commit(4, 9, 32'h22); step();
        total++; if (_dep_rd_1 !== 5'd0) $display("FAIL young_commit_dep got %0d want 0", _dep_rd_1); else passed++;
        total++; if (_dep_value_1 !== 32'h22) $display("FAIL young_commit_val got %h want 22", _dep_value_1); else passed++;
    endtask

    task automatic test_simultaneous();
        _ask_rd_1 = 6; _ask_rd_2 = 6;
        launch(6, 4); step();
        commit(6, 4, 32'h55); launch(6, 12); #1;
        total++; if (_dep_rd_1 !== 5'd0) $display("FAIL simul_same_cycle_dep got %0d want 0", _dep_rd_1); else passed++;
        total++; if (_dep_value_1 !== 32'h55) $display("FAIL simul_same_cycle_val got %h want 55", _dep_value_1); else passed++;
        step();
        total++; if (_dep_rd_2 !== 5'd12) $display("FAIL simul_dep got %0d want 12", _dep_rd_2); else passed++;
        total++; if (_dep_value_2 !== 32'h55) $display("FAIL simul_val got %h want 55", _dep_value_2); else passed++;
    endtask

    task automatic test_flush();
        for (int i = 1; i <= 10; i++) begin
            launch(5'(i), 5'(i)); step();
        end
        _ask_rd_1 = 5; _ask_rd_2 = 10; #1;
        total++; if (_dep_rd_1 !== 5'd5) $display("FAIL preflush_dep_x5 got %0d want 5", _dep_rd_1); else passed++;
        total++; if (_dep_rd_2 !== 5'd10) $display("FAIL preflush_dep_x10 got %0d want 10", _dep_rd_2); else passed++;
        _clear = 1; commit(2, 2, 32'h77); launch(11, 11); step();
        for (int i = 1; i <= 11; i++) begin
            _ask_rd_1 = 5'(i); #1;
            total++; if (_dep_rd_1 !== 5'd0) $display("FAIL flush_dep_x%0d got %0d want 0", i, _dep_rd_1); else passed++;
        end
        _ask_rd_2 = 2; #1;
        total++; if (_dep_value_2 !== 32'h77) $display("FAIL flush_commit_val_x2 got %h want 77", _dep_value_2); else passed++;
    endtask

    task automatic test_x0_rdy();
        launch(0, 5); commit(0, 5, 32'hFF); _ask_rd_1 = 0; _ask_rd_2 = 0; step();
        total++; if (_dep_rd_1 !== 5'd0) $display("FAIL x0_dep got %0d want 0", _dep_rd_1); else passed++;
        total++; if (_dep_value_2 !== 32'd0) $display("FAIL x0_val got %h want 0", _dep_value_2); else passed++;
        rdy_in = 0; launch(8, 3); _ask_rd_1 = 8; step();
        total++; if (_dep_rd_1 !== 5'd0) $display("FAIL rdy_low_launch got %0d want 0", _dep_rd_1); else passed++;
        launch(8, 3); commit(8, 0, 32'hABCD); step();
        total++; if (_dep_value_1 !== 32'd0) $display("FAIL rdy_low_commit got %h want 0", _dep_value_1); else passed++;
        rdy_in = 1; launch(8, 3); step();
        total++; if (_dep_rd_1 !== 5'd3) $display("FAIL rdy_high_launch got %0d want 3", _dep_rd_1); else passed++;
    endtask

    initial begin
        rst_in = 1; rdy_in = 1; idle(); _ask_rd_1 = 0; _ask_rd_2 = 0;
        test_reset();
        test_launch_commit();
        test_stale_commit();
        test_simultaneous();
        test_flush();
        test_x0_rdy();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
